button_event_gen: RTL and testbench

- Consumer side of the debounced push-button interface.
- Takes the three clean levels (reset, walk request, reprogram) and turns them into events for the traffic-light controller FSM:
  - single-cycle pulses;
  - a walk-request latch held until the FSM acknowledges it;
  - short/long press classification of the reprogram button.
- Sits between the debouncer and the controller FSM, in the same clock domain.

---
 rtl/button_event_gen_if.sv | 43 ++++
 rtl/button_event_gen.sv | 143 ++++++++++++++
 tb/tb_button_event_gen.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/button_event_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : button_event_gen_if
// Description : Bundle between the debounced button levels / controller
//               acknowledge (master side) and the button event generator
//               (slave side), together with the events it produces.
// Revision    : 1.0 - initial release
// ============================================================================
interface button_event_gen_if;
    logic reset_db_in;
    logic walkRequest_db_in;
    logic reprogram_db_in;
    logic walk_ack;
    logic reset_pulse;
    logic walk_pending;
    logic reprogram_short;
    logic reprogram_long;

    // Debouncer + controller FSM side: supplies levels and ack, consumes events
    modport master (
        output reset_db_in,
        output walkRequest_db_in,
        output reprogram_db_in,
        output walk_ack,
        input  reset_pulse,
        input  walk_pending,
        input  reprogram_short,
        input  reprogram_long
    );

    // Event generator side
    modport slave (
        input  reset_db_in,
        input  walkRequest_db_in,
        input  reprogram_db_in,
        input  walk_ack,
        output reset_pulse,
        output walk_pending,
        output reprogram_short,
        output reprogram_long
    );
endinterface
`default_nettype wire

// File: rtl/button_event_gen.sv
`default_nettype none
// ============================================================================
// Module      : button_event_gen
// Description : Turns debounced button levels into controller events:
//               reset press pulse, latched walk request cleared by ack,
//               and short/long press classification of the reprogram button.
// Revision    : 1.0 - initial release
// ============================================================================
module button_event_gen #(
    parameter int HOLD_CYCLES = 100,
    parameter int CNT_W       = 27
) (
    input  wire logic          clk,
    input  wire logic          sys_reset,
    button_event_gen_if.slave  bus
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_press = 2'd1;
    localparam logic [1:0] c_st_long  = 2'd2;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_zero = '0;

    logic             r_prev_reset;
    logic             r_prev_walk;
    logic             r_prev_reprog;
    logic             r_reset_pulse;
    logic             r_walk_pending;
    logic             r_reprog_short;
    logic             r_reprog_long;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;

    logic             w_reset_rise;
    logic             w_walk_rise;
    logic             w_reprog_rise;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_short_nxt;
    logic             w_long_nxt;

    assign w_reset_rise  = bus.reset_db_in       & ~r_prev_reset;
    assign w_walk_rise   = bus.walkRequest_db_in & ~r_prev_walk;
    assign w_reprog_rise = bus.reprogram_db_in   & ~r_prev_reprog;

    // Previous-level capture; loads 1 in reset so a button held through reset
    // does not look like a fresh press afterwards.
    always_ff @(posedge clk) begin
        if (!sys_reset) begin
            r_prev_reset  <= 1'b1;
            r_prev_walk   <= 1'b1;
            r_prev_reprog <= 1'b1;
        end else begin
            r_prev_reset  <= bus.reset_db_in;
            r_prev_walk   <= bus.walkRequest_db_in;
            r_prev_reprog <= bus.reprogram_db_in;
        end
    end

    // Reset-button pulse and walk latch (reset event > new walk > ack).
    always_ff @(posedge clk) begin
        if (!sys_reset) begin
            r_reset_pulse  <= 1'b0;
            r_walk_pending <= 1'b0;
        end else begin
            r_reset_pulse <= w_reset_rise;
            if (w_reset_rise) begin
                r_walk_pending <= 1'b0;
            end else if (w_walk_rise) begin
                r_walk_pending <= 1'b1;
            end else if (bus.walk_ack && r_walk_pending) begin
                r_walk_pending <= 1'b0;
            end
        end
    end

    // Reprogram FSM next state, hold count and press-classification pulses.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_short_nxt = 1'b0;
        w_long_nxt  = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_reprog_rise) begin
                    w_state_nxt = c_st_press;
                    w_cnt_nxt   = c_cnt_one;
                end
            end
            c_st_press: begin
                if (w_reset_rise) begin
                    // Press abandoned silently by a reset-button event
                    w_state_nxt = c_st_idle;
                    w_cnt_nxt   = c_cnt_zero;
                end else if (!bus.reprogram_db_in) begin
                    w_short_nxt = 1'b1;
                    w_state_nxt = c_st_idle;
                    w_cnt_nxt   = c_cnt_zero;
                end else if (r_cnt == c_cnt_last) begin
                    // Count parks at its last value; no wrap while in LONG
                    w_long_nxt  = 1'b1;
                    w_state_nxt = c_st_long;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            c_st_long: begin
                if (w_reset_rise || !bus.reprogram_db_in) begin
                    w_state_nxt = c_st_idle;
                    w_cnt_nxt   = c_cnt_zero;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_cnt_nxt   = c_cnt_zero;
            end
        endcase
    end

    // Reprogram FSM state register.
    always_ff @(posedge clk) begin
        if (!sys_reset) begin
            r_state        <= c_st_idle;
            r_cnt          <= c_cnt_zero;
            r_reprog_short <= 1'b0;
            r_reprog_long  <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_reprog_short <= w_short_nxt;
            r_reprog_long  <= w_long_nxt;
        end
    end

    assign bus.reset_pulse     = r_reset_pulse;
    assign bus.walk_pending    = r_walk_pending;
    assign bus.reprogram_short = r_reprog_short;
    assign bus.reprogram_long  = r_reprog_long;

endmodule
`default_nettype wire

// File: tb/tb_button_event_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_event_gen
// Description : Directed self-checking bench for button_event_gen with
//               HOLD_CYCLES = 8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_event_gen;

    localparam int c_hold = 8;

    logic clk;
    logic sys_reset;
    int   n_checks;
    int   n_fails;

    button_event_gen_if bus ();

    button_event_gen #(
        .HOLD_CYCLES (c_hold),
        .CNT_W       (27)
    ) u_dut (
        .clk       (clk),
        .sys_reset (sys_reset),
        .bus       (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int rp, input int wp,
                              input int rs, input int rl);
        check({tag, ".reset_pulse"},     int'(bus.reset_pulse),     rp);
        check({tag, ".walk_pending"},    int'(bus.walk_pending),    wp);
        check({tag, ".reprogram_short"}, int'(bus.reprogram_short), rs);
        check({tag, ".reprogram_long"},  int'(bus.reprogram_long),  rl);
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_long;
        int n_short;
        n_checks = 0;
        n_fails  = 0;

        // 1: reset with all buttons held
        sys_reset              = 1'b0;
        bus.reset_db_in        = 1'b1;
        bus.walkRequest_db_in  = 1'b1;
        bus.reprogram_db_in    = 1'b1;
        bus.walk_ack           = 1'b0;
        repeat (3) tick();
        check_outs("rst_state", 0, 0, 0, 0);
        sys_reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_outs("held_after_rst", 0, 0, 0, 0);
        end
        bus.walkRequest_db_in = 1'b0;
        tick();
        check("walk_low", int'(bus.walk_pending), 0);
        bus.walkRequest_db_in = 1'b1;
        tick();
        check("walk_set", int'(bus.walk_pending), 1);
        bus.walk_ack = 1'b1;
        tick();
        check("walk_ack_clr", int'(bus.walk_pending), 0);
        bus.walk_ack           = 1'b0;
        bus.reset_db_in        = 1'b0;
        bus.walkRequest_db_in  = 1'b0;
        bus.reprogram_db_in    = 1'b0;
        tick();
        check_outs("idle", 0, 0, 0, 0);

        // 2: reset button held 10 cycles gives a single pulse
        bus.reset_db_in = 1'b1;
        tick();
        check("rpulse_first", int'(bus.reset_pulse), 1);
        for (int i = 0; i < 9; i++) begin
            tick();
            check("rpulse_hold", int'(bus.reset_pulse), 0);
        end
        bus.reset_db_in = 1'b0;
        tick();

        // 3: walk latch and acknowledge
        bus.walkRequest_db_in = 1'b1;
        tick();
        check("walk3_set", int'(bus.walk_pending), 1);
        bus.walkRequest_db_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("walk3_hold", int'(bus.walk_pending), 1);
        end
        bus.walk_ack = 1'b1;
        tick();
        check("walk3_ack", int'(bus.walk_pending), 0);
        bus.walk_ack = 1'b0;
        bus.walkRequest_db_in = 1'b1;
        tick();
        check("walk3_reset", int'(bus.walk_pending), 1);
        bus.walkRequest_db_in = 1'b0;
        tick();
        bus.walkRequest_db_in = 1'b1;
        bus.walk_ack          = 1'b1;
        tick();
        check("walk_rise_and_ack", int'(bus.walk_pending), 1);
        bus.walk_ack = 1'b0;
        tick();
        check("walk_repress", int'(bus.walk_pending), 1);
        bus.walk_ack = 1'b1;
        tick();
        check("walk_ack_held_btn", int'(bus.walk_pending), 0);
        tick();
        check("walk_ack_not_pend", int'(bus.walk_pending), 0);
        bus.walk_ack          = 1'b0;
        bus.walkRequest_db_in = 1'b0;
        tick();

        // 4a: HOLD-1 edges high is a short press
        bus.reprogram_db_in = 1'b1;
        for (int i = 0; i < c_hold - 1; i++) begin
            tick();
            check_outs("short_hold", 0, 0, 0, 0);
        end
        bus.reprogram_db_in = 1'b0;
        tick();
        check_outs("short_rel", 0, 0, 1, 0);
        tick();
        check_outs("short_after", 0, 0, 0, 0);

        // 4b: single-edge press is short
        bus.reprogram_db_in = 1'b1;
        tick();
        bus.reprogram_db_in = 1'b0;
        tick();
        check("short_min", int'(bus.reprogram_short), 1);
        tick();

        // 4c: exactly HOLD edges is long, on the last edge
        bus.reprogram_db_in = 1'b1;
        for (int i = 0; i < c_hold - 1; i++) begin
            tick();
            check("long_pre", int'(bus.reprogram_long), 0);
        end
        tick();
        check_outs("long_edge", 0, 0, 0, 1);
        tick();
        check_outs("long_after", 0, 0, 0, 0);
        bus.reprogram_db_in = 1'b0;
        tick();
        check_outs("long_rel", 0, 0, 0, 0);
        tick();

        // 4d: 20-edge press gives one long, no short
        n_long  = 0;
        n_short = 0;
        bus.reprogram_db_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_long  += int'(bus.reprogram_long);
            n_short += int'(bus.reprogram_short);
        end
        bus.reprogram_db_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_long  += int'(bus.reprogram_long);
            n_short += int'(bus.reprogram_short);
        end
        check("long20_count", n_long, 1);
        check("long20_short", n_short, 0);

        // 5: reset-button event abandons a press and clears the walk latch
        bus.walkRequest_db_in = 1'b1;
        tick();
        bus.walkRequest_db_in = 1'b0;
        check("walk5_set", int'(bus.walk_pending), 1);
        bus.reprogram_db_in = 1'b1;
        repeat (4) tick();
        bus.reset_db_in = 1'b1;
        tick();
        check_outs("abandon_edge", 1, 0, 0, 0);
        bus.reset_db_in = 1'b0;
        n_long  = 0;
        n_short = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_long  += int'(bus.reprogram_long);
            n_short += int'(bus.reprogram_short);
        end
        bus.reprogram_db_in = 1'b0;
        repeat (2) begin
            tick();
            n_long  += int'(bus.reprogram_long);
            n_short += int'(bus.reprogram_short);
        end
        check("abandon_long", n_long, 0);
        check("abandon_short", n_short, 0);
        bus.reprogram_db_in = 1'b1;
        repeat (3) tick();
        bus.reprogram_db_in = 1'b0;
        tick();
        check("recover_short", int'(bus.reprogram_short), 1);
        tick();

        // 6: system reset mid-press, button still held afterwards
        bus.walkRequest_db_in = 1'b1;
        tick();
        bus.walkRequest_db_in = 1'b0;
        bus.reprogram_db_in   = 1'b1;
        repeat (5) tick();
        sys_reset = 1'b0;
        tick();
        check_outs("sysrst_mid", 0, 0, 0, 0);
        sys_reset = 1'b1;
        n_long  = 0;
        n_short = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_long  += int'(bus.reprogram_long);
            n_short += int'(bus.reprogram_short);
        end
        bus.reprogram_db_in = 1'b0;
        repeat (2) begin
            tick();
            n_long  += int'(bus.reprogram_long);
            n_short += int'(bus.reprogram_short);
        end
        check("sysrst_long", n_long, 0);
        check("sysrst_short", n_short, 0);
        bus.reprogram_db_in = 1'b1;
        repeat (c_hold) tick();
        check("sysrst_relong", int'(bus.reprogram_long), 1);
        bus.reprogram_db_in = 1'b0;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
